// File: rtl/i8259_lite.sv
// Reduced 8259-style interrupt controller: edge-triggered requests, fixed priority (ir[0] highest),
// IMR/IRR/ISR registers, vectored acknowledge and EOI commands over a small host register port.
module i8259_lite (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] ir,
    output logic       intr,
    input  logic       inta,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic [2:0] {
        CMD_RSEL  = 3'b000,
        CMD_NSEOI = 3'b001,
        CMD_SEOI  = 3'b011,
        CMD_VB    = 3'b110
    } cmd_e;

    logic [7:0] imr_q, imr_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [4:0] vb_q, vb_d;
    logic [1:0] rsel_q, rsel_d;
    logic [7:0] ir_prev_q;
    logic       intr_q, intr_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q;

    logic [7:0] ir_edge;
    logic [7:0] pending;
    logic [2:0] lvl_l;
    logic [3:0] lvl_s;
    logic       grant;
    logic       host_wr;
    cmd_e       cmd;

    // Priority resolution always uses the pre-edge register state.
    always_comb begin
        ir_edge = ir & ~ir_prev_q;
        pending = irr_q & ~imr_q;
        lvl_l   = 3'd0;
        lvl_s   = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) lvl_l = 3'(i);
            if (isr_q[i])   lvl_s = 4'(i);
        end
        grant   = (pending != 8'd0) && ({1'b0, lvl_l} < lvl_s);
        host_wr = cs & wr;
        cmd     = cmd_e'(din[7:5]);
    end

    always_comb begin
        imr_d    = imr_q;
        irr_d    = irr_q;
        isr_d    = isr_q;
        vb_d     = vb_q;
        rsel_d   = rsel_q;
        vector_d = vector_q;
        intr_d   = grant;

        if (host_wr && a) begin
            imr_d = din;
        end else if (host_wr) begin
            case (cmd)
                CMD_NSEOI: if (!lvl_s[3]) isr_d[lvl_s[2:0]] = 1'b0;
                CMD_SEOI:  isr_d[din[2:0]] = 1'b0;
                CMD_VB:    vb_d = din[4:0];
                CMD_RSEL:  if (din[1]) rsel_d = din[1:0];
                default:   ;
            endcase
        end

        // EOI is applied first so an acknowledge of the same level leaves the bit set.
        if (inta && grant) begin
            irr_d[lvl_l] = 1'b0;
            isr_d[lvl_l] = 1'b1;
            vector_d     = {vb_q, lvl_l};
        end else if (inta) begin
            vector_d = {vb_q, 3'd7};
        end

        // A fresh edge re-requests even the level being acknowledged this cycle.
        irr_d = irr_d | ir_edge;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            imr_q          <= 8'hFF;
            irr_q          <= 8'h00;
            isr_q          <= 8'h00;
            vb_q           <= 5'd0;
            rsel_q         <= 2'b10;
            ir_prev_q      <= 8'hFF;
            intr_q         <= 1'b0;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
        end else begin
            imr_q          <= imr_d;
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            vb_q           <= vb_d;
            rsel_q         <= rsel_d;
            ir_prev_q      <= ir;
            intr_q         <= intr_d;
            vector_q       <= vector_d;
            vector_valid_q <= inta;
        end
    end

    always_comb begin
        dout = 8'h00;
        if (cs && rd) begin
            if (a)                    dout = imr_q;
            else if (rsel_q == 2'b10) dout = irr_q;
            else if (rsel_q == 2'b11) dout = isr_q;
        end
    end

    assign intr         = intr_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: doc/i8259_lite.md
I8259_LITE -- requirements
Module: i8259_lite

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 cs  input  1  chip select for host register access.
REQ-004 rd  input  1  host read strobe, qualified by cs.
REQ-005 wr  input  1  host write strobe, qualified by cs; one write per cycle where wr&cs=1.
REQ-006 a  input  1  register address: 0 = command/status, 1 = mask.
REQ-007 din  input  8  host write data.
REQ-008 dout  output  8  host read data; combinational; 0 when rd&cs=0.
REQ-009 ir  input  8  interrupt requests; ir[0..2] driven by the i8253 out[2:0]; ir[0] is highest priority.
REQ-010 intr  output  1  registered interrupt request to the CPU.
REQ-011 inta  input  1  one-cycle acknowledge pulse from the CPU.
REQ-012 vector  output  8  registered interrupt vector.
REQ-013 vector_valid  output  1  one-cycle pulse, high the cycle after the inta is sampled.

Function
REQ-014 Registers: IMR[7:0] mask, IRR[7:0] request, ISR[7:0] in-service, VB[4:0] vector base, RSEL[1:0] status select, ir_prev[7:0] edge sampler.
REQ-015 ir_prev SHALL load ir every cycle; edge[i] = ir[i] & ~ir_prev[i].
REQ-016 IRR[i] SHALL set on the clock edge where edge[i]=1, regardless of IMR; a level held high SHALL NOT re-request.
REQ-017 Pending = IRR & ~IMR; L = lowest-index set bit of pending; S = lowest-index set bit of ISR (S=8 when ISR=0).
REQ-018 intr SHALL be registered as (pending != 0) and (L < S); intr therefore rises one cycle after IRR sets.
REQ-019 On inta=1 with pending != 0 and L < S: IRR[L] <= 0, ISR[L] <= 1, vector <= {VB, L}.
REQ-020 On inta=1 otherwise (spurious): vector <= {VB, 3'd7}; IRR and ISR unchanged.
REQ-021 vector_valid SHALL be 1 exactly in the cycle following any inta=1, including a spurious inta.
REQ-022 Write with a=1 SHALL set IMR <= din.
REQ-023 Write with a=0, din[7:5]=001 (non-specific EOI) SHALL clear ISR[S]; no effect if ISR=0.
REQ-024 Write with a=0, din[7:5]=011 (specific EOI) SHALL clear ISR[din[2:0]].
REQ-025 Write with a=0, din[7:5]=110 SHALL set VB <= din[4:0].
REQ-026 Write with a=0, din[7:5]=000, din[1]=1 SHALL set RSEL <= din[1:0].
REQ-027 All other a=0 command codes SHALL be ignored.
REQ-028 Read with a=1 SHALL return IMR; a=0 SHALL return IRR when RSEL=10 and ISR when RSEL=11.
REQ-029 Simultaneous edge[L] and inta acking L: IRR[L] SHALL end at 1, because the new edge is a new request.
REQ-030 Simultaneous EOI and inta: S and L SHALL be computed from pre-edge state; both updates SHALL apply.
REQ-031 If the EOI and the inta target the same ISR bit, the ISR set from the inta SHALL win.
REQ-032 The IMR value written in a cycle SHALL take effect for L and intr from the next cycle.
REQ-033 Nested interrupts: a request with higher priority than S SHALL assert intr while ISR is nonzero; a request with equal or lower priority SHALL NOT.

Reset
REQ-034 Reset values: IMR=8'hFF, IRR=0, ISR=0, VB=0, RSEL=10, intr=0, vector=0, vector_valid=0.
REQ-035 ir_prev SHALL be loaded with 8'hFF, so a line high during reset produces no edge.
REQ-036 Reset SHALL override any simultaneous host write, inta or ir edge.
REQ-037 Reset mid-service SHALL clear ISR and IRR; intr SHALL be 0 in the cycle after reset.

Verification
REQ-038 Reset; write IMR=8'hFE; VB=5'h04; pulse ir[0] -> IRR=01 next edge, intr=1 one cycle later; inta -> vector=8'h20, vector_valid pulse, ISR=01, intr=0.
REQ-039 ISR=01 in service; IMR=00; pulse ir[2] -> intr stays 0; non-specific EOI -> ISR=00, then intr=1; inta -> vector=8'h22.
REQ-040 IMR=00, ISR=04; pulse ir[1] -> intr=1; inta -> ISR=06; specific EOI level 1 -> ISR=04.
REQ-041 inta with no pending request -> vector={VB,3'd7}, vector_valid=1, ISR and IRR unchanged.
REQ-042 ir[3] held high through reset, then kept high -> IRR stays 00; drop and re-raise -> IRR=08.
REQ-043 Write cmd 8'h0B, read a=0 -> ISR; write 8'h0A, read a=0 -> IRR; read a=1 -> IMR; rd=0 -> dout=0.
